// File: rtl/mac_pkg.sv
// Shared types and helpers for the 4-lane 8-bit MAC dot-product sequencer.
package mac_pkg;

  localparam int MAC_LANES = 4;
  localparam int MAC_LEN_W = 16;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_RUN  = 2'd1,
    MAC_DONE = 2'd2
  } mac_seq_state_e;

  typedef struct packed {
    logic [MAC_LEN_W-1:0] len;
    logic [31:0]          bias;
    logic                 relu;
  } mac_cmd_t;

  // Negative results clamp to zero only when the command asked for ReLU.
  function automatic logic [31:0] apply_relu(input logic [31:0] value, input logic relu);
    return (relu && value[31]) ? 32'd0 : value;
  endfunction

endpackage

// File: rtl/mac4b_with_input.sv
// Combinational 4-lane MAC: sum_out = sum_in + sum_k({0,act_k} * signed wgt_k), wrapping mod 2^32.
module mac4b_with_input
  import mac_pkg::*;
(
  input  logic [31:0] act,
  input  logic [31:0] wgt,
  input  logic [31:0] sum_in,
  output logic [31:0] sum_out
);

  logic signed [15:0] act_ext  [MAC_LANES];
  logic signed [15:0] wgt_ext  [MAC_LANES];
  logic signed [15:0] prod     [MAC_LANES];
  logic signed [17:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < MAC_LANES; k++) begin
      // Activations are unsigned (zero-extend), weights are signed (sign-extend).
      act_ext[k] = $signed({8'd0, act[8*k +: 8]});
      wgt_ext[k] = $signed({{8{wgt[8*k+7]}}, wgt[8*k +: 8]});
      prod[k]    = act_ext[k] * wgt_ext[k];
      lane_sum   = lane_sum + 18'(prod[k]);
    end
  end

  assign sum_out = sum_in + {{14{lane_sum[17]}}, lane_sum};

endmodule

// File: rtl/mac4b_dot_seq.sv
// Sequences one command plus a stream of operand beats through the 4-lane MAC into one result.
module mac4b_dot_seq
  import mac_pkg::*;
#(
  parameter int LEN_W = MAC_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [31:0]      cmd_bias_i,
  input  logic             cmd_relu_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_act_i,
  input  logic [31:0]      op_wgt_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. Every ready/valid
  // output is a pure decode of state, so no combinational path exists from any valid input.
  mac_seq_state_e   state_q;
  logic [31:0]      acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic             relu_q;
  logic [31:0]      res_q;
  logic [31:0]      mac_sum;

  mac4b_with_input u_mac (
    .act     (op_act_i),
    .wgt     (op_wgt_i),
    .sum_in  (acc_q),
    .sum_out (mac_sum)
  );

  assign cmd_ready_o = (state_q == MAC_IDLE);
  assign op_ready_o  = (state_q == MAC_RUN);
  assign res_valid_o = (state_q == MAC_DONE);
  assign busy_o      = (state_q != MAC_IDLE);
  assign res_data_o  = res_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MAC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      res_q   <= '0;
    end else if (clear_i) begin
      // Abort wins over any handshake this cycle; a pending result is discarded.
      state_q <= MAC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MAC_IDLE: begin
          if (cmd_valid_i) begin
            acc_q  <= cmd_bias_i;
            relu_q <= cmd_relu_i;
            cnt_q  <= cmd_len_i;
            if (cmd_len_i == '0) begin
              state_q <= MAC_DONE;
              res_q   <= apply_relu(cmd_bias_i, cmd_relu_i);
            end else begin
              state_q <= MAC_RUN;
            end
          end
        end
        MAC_RUN: begin
          if (op_valid_i) begin
            acc_q <= mac_sum;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q <= MAC_DONE;
              res_q   <= apply_relu(mac_sum, relu_q);
            end
          end
        end
        MAC_DONE: begin
          if (res_ready_i) state_q <= MAC_IDLE;
        end
        default: state_q <= MAC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac4b_dot_seq.sv
// Directed and randomized bench for mac4b_dot_seq against a plain-arithmetic dot-product model.
module tb_mac4b_dot_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [15:0] cmd_len_i = '0;
  logic [31:0] cmd_bias_i = '0;
  logic        cmd_relu_i = 1'b0;
  logic        op_valid_i = 1'b0;
  logic        op_ready_o;
  logic [31:0] op_act_i = '0;
  logic [31:0] op_wgt_i = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] act_a [8];
  logic [31:0] wgt_a [8];
  int          gap_a [8];

  mac4b_dot_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_len_i   (cmd_len_i),
    .cmd_bias_i  (cmd_bias_i),
    .cmd_relu_i  (cmd_relu_i),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_act_i    (op_act_i),
    .op_wgt_i    (op_wgt_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .busy_o      (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: bias plus signed dot product in wide integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] model_result(input int len, input logic [31:0] bias,
                                               input logic relu);
    longint total;
    longint a, w;
    logic [31:0] r;
    total = longint'($signed(bias));
    for (int i = 0; i < len; i++)
      for (int k = 0; k < 4; k++) begin
        a = longint'((act_a[i] >> (8*k)) & 32'hFF);
        w = longint'((wgt_a[i] >> (8*k)) & 32'hFF);
        if (w > 127) w = w - 256;
        total = total + a * w;
      end
    r = total[31:0];
    if (relu && $signed(r) < 0) r = 32'd0;
    return r;
  endfunction

  // ---------------- drivers (start and end on a falling edge) ----------------
  task automatic send_cmd(input int len, input logic [31:0] bias, input logic relu);
    check("cmd_ready_before_cmd", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_len_i   = 16'(len);
    cmd_bias_i  = bias;
    cmd_relu_i  = relu;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_len_i   = 16'($urandom);
    cmd_bias_i  = $urandom;
    cmd_relu_i  = 1'($urandom);
  endtask

  task automatic send_beat(input logic [31:0] act, input logic [31:0] wgt, input int gap);
    int budget;
    repeat (gap) @(negedge clk_i);
    op_valid_i = 1'b1;
    op_act_i   = act;
    op_wgt_i   = wgt;
    budget = 50;
    while (!op_ready_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    check("op_ready_wait", {31'd0, op_ready_o}, 32'd1);
    @(negedge clk_i);
    op_valid_i = 1'b0;
    op_act_i   = $urandom;
    op_wgt_i   = $urandom;
  endtask

  task automatic get_result(input string tag, input int hold);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check({tag, "_hold_valid"}, {31'd0, res_valid_o}, 32'd1);
      check({tag, "_hold_data"}, res_data_o, exp);
    end
    check({tag, "_data"}, res_data_o, exp);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    check({tag, "_idle_after"}, {30'd0, busy_o, res_valid_o}, 32'd0);
  endtask

  // Runs a command over act_a/wgt_a/gap_a; result appears right after the last handshake.
  task automatic run_cmd(input string tag, input int len, input logic [31:0] bias,
                         input logic relu, input int hold);
    exp_q.push_back(model_result(len, bias, relu));
    send_cmd(len, bias, relu);
    if (len == 0) begin
      check({tag, "_no_op_ready"}, {31'd0, op_ready_o}, 32'd0);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (i > 0) check({tag, "_not_done_early"}, {31'd0, res_valid_o}, 32'd0);
        send_beat(act_a[i], wgt_a[i], gap_a[i]);
      end
    end
    get_result(tag, hold);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 8; i++) begin
      act_a[i] = '0;
      wgt_a[i] = '0;
      gap_a[i] = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_tables();
    #12;
    @(negedge clk_i);
    check("reset_outputs", {27'd0, cmd_ready_o, op_ready_o, res_valid_o, busy_o, 1'b0}, 32'h10);
    check("reset_res_data", res_data_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Test 1: simple sum of 1+2+3+4.
    act_a[0] = 32'h04030201; wgt_a[0] = 32'h01010101;
    exp_q.push_back(32'd10);
    send_cmd(1, 32'd0, 1'b0);
    send_beat(act_a[0], wgt_a[0], 0);
    get_result("t1", 0);

    // Test 2: unsigned 255 times signed -128 on every lane.
    act_a[0] = 32'hFFFFFFFF; wgt_a[0] = 32'h80808080;
    exp_q.push_back(32'hFFFE0200);
    send_cmd(1, 32'd0, 1'b0);
    send_beat(act_a[0], wgt_a[0], 0);
    get_result("t2", 0);

    // Test 3: three beats with gaps, consumer stalls 5 cycles.
    act_a[0] = 32'h01010101; wgt_a[0] = 32'h02020202; gap_a[0] = 2;
    act_a[1] = 32'h0A000000; wgt_a[1] = 32'hFF000000; gap_a[1] = 2;
    act_a[2] = 32'h00000003; wgt_a[2] = 32'h00000005; gap_a[2] = 2;
    exp_q.push_back(32'd113);
    send_cmd(3, 32'd100, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(act_a[i], wgt_a[i], gap_a[i]);
    get_result("t3", 5);
    clear_tables();

    // Test 4: zero-length command, op_valid ignored.
    op_valid_i = 1'b1;
    exp_q.push_back(32'h12345678);
    send_cmd(0, 32'h12345678, 1'b0);
    check("t4_no_op_ready", {31'd0, op_ready_o}, 32'd0);
    get_result("t4", 2);
    op_valid_i = 1'b0;

    // Test 5a/5b: ReLU clamp and wrap without saturation.
    exp_q.push_back(32'd0);
    send_cmd(0, 32'hFFFFFFFB, 1'b1);
    get_result("t5a", 0);
    act_a[0] = 32'h1; wgt_a[0] = 32'h1;
    exp_q.push_back(32'h80000000);
    send_cmd(1, 32'h7FFFFFFF, 1'b0);
    send_beat(act_a[0], wgt_a[0], 0);
    get_result("t5b", 0);

    // Test 6a: async reset mid-run.
    send_cmd(4, 32'd7, 1'b0);
    send_beat(32'h01020304, 32'h05060708, 0);
    rst_i = 1'b1;
    #1;
    check("t6a_reset_flags", {28'd0, cmd_ready_o, op_ready_o, res_valid_o, busy_o}, 32'h8);
    check("t6a_reset_data", res_data_o, 32'd0);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    act_a[0] = 32'h00000010; wgt_a[0] = 32'h000000FE;
    run_cmd("t6a_after", 1, 32'd5, 1'b0, 0);

    // Test 6b: clear in DONE drops the result.
    send_cmd(0, 32'hCAFEF00D, 1'b0);
    check("t6b_in_done", {31'd0, res_valid_o}, 32'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check("t6b_cleared", {30'd0, busy_o, res_valid_o}, 32'd0);
    act_a[0] = 32'h7F7F7F7F; wgt_a[0] = 32'h81818181;
    run_cmd("t6b_after", 1, 32'd0, 1'b1, 1);

    // Clear in IDLE blocks a simultaneous command.
    clear_i = 1'b1; cmd_valid_i = 1'b1; cmd_len_i = 16'd0;
    @(negedge clk_i);
    clear_i = 1'b0; cmd_valid_i = 1'b0;
    check("idle_clear_blocks_cmd", {31'd0, busy_o}, 32'd0);

    // Randomized commands.
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) begin
        act_a[i] = $urandom;
        wgt_a[i] = $urandom;
        gap_a[i] = $urandom_range(0, 2);
      end
      run_cmd("rand", len, $urandom, 1'($urandom), $urandom_range(0, 3));
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
